param_sync_fifo: RTL and testbench

- Parametrised single-clock FIFO for command and data queues in the DRAM global controller.
- Supersedes the fixed-flag FIFO with a selectable output mode (first-word-fall-through or registered), an occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Sits between frontend command issue and the backend schedulers.

---
 rtl/param_sync_fifo.sv | 146 ++++++++++++++
 tb/tb_param_sync_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO for command/data queues with selectable FWFT or registered read, occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow flags.
// Ports: i_clk/i_rst_n (async active-low), i_flush, write side (i_wr_en, i_wr_data), read side
// (i_rd_en, o_rd_data, o_rd_valid), status (o_count, o_full, o_empty, o_almost_*), errors (o_overflow,
// o_underflow, i_clr_err). All flags are registered and valid the cycle after the causing edge.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic                  o_overflow,
    output logic                  o_underflow,
    input  logic                  i_clr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH && ADDR_WIDTH >= 1)) begin : g_bad_params
        $error("param_sync_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH and ADDR_WIDTH >= 1");
    end

    typedef logic [ADDR_WIDTH:0] ptr_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ptr_t wr_ptr, rd_ptr;
    ptr_t wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic wr_req, rd_req;
    logic full_nxt, empty_nxt;
    logic ovf_set;
    logic ovf_q;

    // Requests are qualified by the registered flags; flush suppresses both.
    always_comb begin
        wr_req     = i_wr_en & ~o_full & ~i_flush;
        rd_req     = i_rd_en & ~o_empty & ~i_flush;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (i_flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (wr_req) wr_ptr_nxt = wr_ptr + ptr_t'(1);
            if (rd_req) rd_ptr_nxt = rd_ptr + ptr_t'(1);
        end
        count_nxt = wr_ptr_nxt - rd_ptr_nxt;
        // MSB is the wrap bit: equal low bits with differing wrap bits means full.
        empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt  = (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
        // A write dropped by flush is not an overflow.
        ovf_set   = i_wr_en & o_full & ~i_flush;
    end

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (wr_req) mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_count        <= '0;
            o_empty        <= 1'b1;
            o_full         <= 1'b0;
            o_almost_empty <= 1'b1;
            o_almost_full  <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            o_count        <= count_nxt;
            o_empty        <= empty_nxt;
            o_full         <= full_nxt;
            o_almost_empty <= (int'(count_nxt) <= AE_LEVEL);
            o_almost_full  <= (int'(count_nxt) >= AF_LEVEL);
            // Set beats clear when both occur in the same cycle.
            ovf_q          <= ovf_set | (ovf_q & ~i_clr_err);
        end
    end

    assign o_overflow = ovf_q;

    if (FWFT != 0) begin : g_fwft
        // Head word is visible combinationally; driven to zero while empty so reset shows zero.
        assign o_rd_data   = o_empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
        assign o_rd_valid  = ~o_empty;
        assign o_underflow = 1'b0;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;
        logic                  unf_q;
        logic                  unf_set;

        assign unf_set = i_rd_en & o_empty & ~i_flush;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
                unf_q      <= 1'b0;
            end else begin
                if (rd_req) rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_valid_q <= rd_req;
                unf_q      <= unf_set | (unf_q & ~i_clr_err);
            end
        end

        assign o_rd_data   = rd_data_q;
        assign o_rd_valid  = rd_valid_q;
        assign o_underflow = unf_q;

        a_rd_data: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            rd_req |=> (o_rd_data == $past(mem[rd_ptr[ADDR_WIDTH-1:0]])));
    end

    a_no_wr_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_wr_en && o_full && !i_flush) |=> (wr_ptr == $past(wr_ptr)));
    a_no_rd_when_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_rd_en && o_empty && !i_flush) |=> (rd_ptr == $past(rd_ptr)));
    a_wr_step: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        wr_req |=> (wr_ptr == $past(wr_ptr) + ptr_t'(1)));
    a_rd_step: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        rd_req |=> (rd_ptr == $past(rd_ptr) + ptr_t'(1)));
    a_count: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_count == ptr_t'(wr_ptr - rd_ptr));
    a_wr_data: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        wr_req |=> (mem[$past(wr_ptr[ADDR_WIDTH-1:0])] == $past(i_wr_data)));

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomized and directed bench for param_sync_fifo: instance A in FWFT mode, instance B in registered mode,
// each compared every cycle against a queue-based reference model.
// Latency/backpressure are modelled from the occupancy rules alone.
module tb_param_sync_fifo;

    logic        clk;
    logic        rst_n;

    logic        a_flush, a_wr, a_rd, a_clr;
    logic [31:0] a_wdat, a_rdata;
    logic        a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [4:0]  a_count;

    logic        b_flush, b_wr, b_rd, b_clr;
    logic [31:0] b_wdat, b_rdata;
    logic        b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [4:0]  b_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        ea_ovf, eb_ovf, eb_unf, eb_rv;
    logic [31:0] eb_rdata;

    param_sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush), .i_wr_en(a_wr), .i_wr_data(a_wdat),
        .i_rd_en(a_rd), .o_rd_data(a_rdata), .o_rd_valid(a_rv), .o_count(a_count), .o_full(a_full),
        .o_empty(a_empty), .o_almost_full(a_af), .o_almost_empty(a_ae), .o_overflow(a_ovf),
        .o_underflow(a_unf), .i_clr_err(a_clr)
    );

    param_sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(0)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush), .i_wr_en(b_wr), .i_wr_data(b_wdat),
        .i_rd_en(b_rd), .o_rd_data(b_rdata), .o_rd_valid(b_rv), .o_count(b_count), .o_full(b_full),
        .o_empty(b_empty), .o_almost_full(b_af), .o_almost_empty(b_ae), .o_overflow(b_ovf),
        .o_underflow(b_unf), .i_clr_err(b_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int sa;
        int sb;
        sa = qa.size();
        sb = qb.size();
        chk("a_count", 64'(a_count), 64'(sa));
        chk("a_full",  64'(a_full),  64'(sa == 16));
        chk("a_empty", 64'(a_empty), 64'(sa == 0));
        chk("a_af",    64'(a_af),    64'(sa >= 12));
        chk("a_ae",    64'(a_ae),    64'(sa <= 2));
        chk("a_rv",    64'(a_rv),    64'(sa > 0));
        if (sa > 0) chk("a_rdata", 64'(a_rdata), 64'(qa[0]));
        chk("a_ovf",   64'(a_ovf),   64'(ea_ovf));
        chk("a_unf",   64'(a_unf),   64'(0));
        chk("b_count", 64'(b_count), 64'(sb));
        chk("b_full",  64'(b_full),  64'(sb == 16));
        chk("b_empty", 64'(b_empty), 64'(sb == 0));
        chk("b_af",    64'(b_af),    64'(sb >= 12));
        chk("b_ae",    64'(b_ae),    64'(sb <= 2));
        chk("b_rv",    64'(b_rv),    64'(eb_rv));
        chk("b_rdata", 64'(b_rdata), 64'(eb_rdata));
        chk("b_ovf",   64'(b_ovf),   64'(eb_ovf));
        chk("b_unf",   64'(b_unf),   64'(eb_unf));
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        ea_ovf   = 1'b0;
        eb_ovf   = 1'b0;
        eb_unf   = 1'b0;
        eb_rv    = 1'b0;
        eb_rdata = '0;
    endtask

    task automatic idle();
        a_flush = 0; a_wr = 0; a_rd = 0; a_clr = 0; a_wdat = '0;
        b_flush = 0; b_wr = 0; b_rd = 0; b_clr = 0; b_wdat = '0;
    endtask

    // One clock: the model consumes the same inputs the DUTs saw at the edge, then everything is compared.
    task automatic step();
        int sa;
        int sb;
        @(posedge clk);
        sa = qa.size();
        sb = qb.size();
        if (a_wr && sa == 16 && !a_flush) ea_ovf = 1'b1;
        else if (a_clr) ea_ovf = 1'b0;
        if (a_flush) qa.delete();
        else begin
            if (a_rd && sa > 0) void'(qa.pop_front());
            if (a_wr && sa < 16) qa.push_back(a_wdat);
        end
        if (b_wr && sb == 16 && !b_flush) eb_ovf = 1'b1;
        else if (b_clr) eb_ovf = 1'b0;
        if (b_rd && sb == 0 && !b_flush) eb_unf = 1'b1;
        else if (b_clr) eb_unf = 1'b0;
        eb_rv = 1'b0;
        if (b_flush) qb.delete();
        else begin
            if (b_rd && sb > 0) begin
                eb_rdata = qb.pop_front();
                eb_rv    = 1'b1;
            end
            if (b_wr && sb < 16) qb.push_back(b_wdat);
        end
        #1;
        check_all();
    endtask

    // Asserts reset between clock edges and checks outputs respond without a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        idle();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        model_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_all();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();

        // 1: fill to full, overflow attempt, drain in order
        for (int i = 0; i < 16; i++) begin
            a_wr = 1; a_wdat = 32'(i);
            step();
            if (i == 10) chk("af_after11", 64'(a_af), 64'(0));
            if (i == 11) chk("af_after12", 64'(a_af), 64'(1));
        end
        chk("full_after16", 64'(a_full), 64'(1));
        chk("count16", 64'(a_count), 64'(16));
        a_wdat = 32'hFF;
        step();
        chk("ovf_set", 64'(a_ovf), 64'(1));
        chk("count_still16", 64'(a_count), 64'(16));
        a_wr = 0;
        for (int i = 0; i < 16; i++) begin
            chk("drain_dat", 64'(a_rdata), 64'(i));
            a_rd = 1;
            step();
        end
        a_rd = 0;
        chk("empty_after_drain", 64'(a_empty), 64'(1));
        a_clr = 1;
        step();
        a_clr = 0;
        chk("ovf_cleared", 64'(a_ovf), 64'(0));

        // 2: occupancy 5 with simultaneous write/read
        for (int i = 0; i < 5; i++) begin
            a_wr = 1; a_wdat = 32'h100 + 32'(i);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            a_wr = 1; a_rd = 1; a_wdat = 32'h200 + 32'(i);
            step();
            chk("steady_count5", 64'(a_count), 64'(5));
        end
        idle();
        while (qa.size() > 0) begin
            a_rd = 1;
            step();
        end
        idle();

        // 3: 40 incrementing words, occupancy kept within 0..3 so both pointers wrap
        begin
            int sent;
            int iter;
            sent = 0;
            iter = 0;
            while ((sent < 40 || qa.size() > 0) && iter < 500) begin
                a_wr = (sent < 40) && (qa.size() < 3) && ($urandom_range(0, 1) == 1);
                a_rd = (qa.size() > 0) && ($urandom_range(0, 1) == 1);
                a_wdat = 32'(sent);
                if (a_wr) sent++;
                step();
                iter++;
            end
            chk("wrap_done", 64'(iter < 500), 64'(1));
        end
        idle();

        // 4: registered mode single read, then underflow
        b_wr = 1; b_wdat = 32'hA5;
        step();
        b_wr = 0; b_rd = 1;
        step();
        chk("b_pulse_vld", 64'(b_rv), 64'(1));
        chk("b_pulse_dat", 64'(b_rdata), 64'hA5);
        b_rd = 0;
        step();
        chk("b_pulse_end", 64'(b_rv), 64'(0));
        chk("b_hold_dat", 64'(b_rdata), 64'hA5);
        b_rd = 1;
        step();
        chk("b_unf_set", 64'(b_unf), 64'(1));
        chk("b_unf_novld", 64'(b_rv), 64'(0));
        b_rd = 0; b_clr = 1;
        step();
        b_clr = 0;
        chk("b_unf_clr", 64'(b_unf), 64'(0));

        // 5: flush with a concurrent write at occupancy 9
        for (int i = 0; i < 9; i++) begin
            a_wr = 1; a_wdat = 32'h300 + 32'(i);
            b_wr = 1; b_wdat = 32'h400 + 32'(i);
            step();
        end
        a_flush = 1; b_flush = 1; a_wdat = 32'hDEAD; b_wdat = 32'hBEEF;
        step();
        idle();
        chk("flush_count", 64'(a_count), 64'(0));
        chk("flush_empty", 64'(a_empty), 64'(1));
        chk("flush_ae", 64'(a_ae), 64'(1));
        chk("flush_ovf", 64'(a_ovf), 64'(0));
        chk("flush_b_hold", 64'(b_rdata), 64'hA5);
        step();

        // 6: asynchronous reset mid-burst at occupancy 7
        for (int i = 0; i < 7; i++) begin
            a_wr = 1; a_wdat = 32'h500 + 32'(i);
            b_wr = 1; b_wdat = 32'h600 + 32'(i);
            step();
        end
        async_reset();
        a_wr = 1; a_wdat = 32'h3C;
        b_wr = 1; b_wdat = 32'h3C;
        step();
        idle();
        chk("post_rst_a", 64'(a_rdata), 64'h3C);
        b_rd = 1;
        step();
        idle();
        chk("post_rst_b", 64'(b_rdata), 64'h3C);
        a_rd = 1;
        step();
        idle();

        // random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            a_wr    = ($urandom_range(0, 9) < 6);
            a_rd    = ($urandom_range(0, 9) < 4);
            a_wdat  = $urandom;
            a_flush = ($urandom_range(0, 49) == 0);
            a_clr   = ($urandom_range(0, 29) == 0);
            b_wr    = ($urandom_range(0, 9) < 5);
            b_rd    = ($urandom_range(0, 9) < 5);
            b_wdat  = $urandom;
            b_flush = ($urandom_range(0, 49) == 0);
            b_clr   = ($urandom_range(0, 29) == 0);
            step();
        end
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
